// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Parametrised integer register file for the decode stage: two registered read
// ports with per-port hold, one write port, a registered mirror of one
// architectural register (a0), hardwired-zero x0, optional write-to-read
// bypass and a soft-clear sequencer that zeroes one register per cycle.
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst       in   asynchronous active-high reset, clears all state
//   rs1/rs2   in   read indices
//   ren1/ren2 in   read enables (0 = corresponding RD holds)
//   rd        in   write index
//   WE3       in   write enable
//   WD3       in   write data
//   clr       in   soft-clear request, sampled only while idle
//   RD1/RD2   out  registered read data
//   a0        out  registered copy of reg[A0_INDEX], updated every edge
//   busy      out  high while the clear sweep is in progress
//   clr_done  out  one-cycle pulse following the final sweep write
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned A0_INDEX      = 10,
    parameter bit          BYPASS        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic                     ren1,
    input  logic                     ren2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic                     WE3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    input  logic                     clr,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic                     busy,
    output logic                     clr_done
);

    localparam int unsigned NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(A0_INDEX);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    // State
    logic [0:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]    rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]    rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]    a0_q, a0_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Combinational helpers
    logic                     idle_c;
    logic                     wr_en_c;
    logic [DATA_WIDTH-1:0]    val1_c;
    logic [DATA_WIDTH-1:0]    val2_c;
    logic [DATA_WIDTH-1:0]    val_a0_c;

    // Read value of index idx as seen by this edge: x0 is zero, a same-cycle
    // write is forwarded only when bypass is enabled.
    function automatic logic [DATA_WIDTH-1:0] read_val(
        input logic [ADDRESS_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0]    stored,
        input logic                     fwd_hit,
        input logic [DATA_WIDTH-1:0]    fwd_data
    );
        logic [DATA_WIDTH-1:0] v;
        if (idx == '0) begin
            v = '0;
        end else if (BYPASS && fwd_hit) begin
            v = fwd_data;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Write qualification: writes only land while idle and never on x0
    assign idle_c  = (state_q == S_IDLE);
    assign wr_en_c = WE3 && (rd != '0) && idle_c;

    assign val1_c   = read_val(rs1,    regs_q[rs1],    wr_en_c && (rd == rs1),    WD3);
    assign val2_c   = read_val(rs2,    regs_q[rs2],    wr_en_c && (rd == rs2),    WD3);
    assign val_a0_c = read_val(A0_IDX, regs_q[A0_IDX], wr_en_c && (rd == A0_IDX), WD3);

    // Next-state: array update, read ports, a0 mirror and clear sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        a0_d    = val_a0_c;

        case (state_q)
            S_IDLE: begin
                if (ren1) begin
                    rd1_d = val1_c;
                end
                if (ren2) begin
                    rd2_d = val2_c;
                end
                if (wr_en_c) begin
                    regs_d[rd] = WD3;
                end
                // The request cycle still completes its own read/write;
                // x0 is already zero so the sweep starts at index 1.
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = ADDRESS_WIDTH'(1);
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                regs_d[cnt_q] = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDRESS_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with asynchronous clear of everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            regs_q  <= '{default: '0};
            rd1_q   <= '0;
            rd2_q   <= '0;
            a0_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            a0_q    <= a0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RD1      = rd1_q;
    assign RD2      = rd2_q;
    assign a0       = a0_q;
    assign busy     = busy_q;
    assign clr_done = done_q;

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
// Self-checking bench for regfile_param. Two instances share all inputs: one
// with bypass enabled, one without. A behavioural model pushes expected
// outputs into a scoreboard queue as each cycle is driven; they are popped
// and compared once the edge has produced the DUT outputs. A vector table
// covers basic read/write/hold behaviour; hand-written sequences cover reset,
// the clear sweep, reset during a sweep and a continuously held clr.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        ren1, ren2, WE3, clr;
    logic [31:0] WD3;

    logic [31:0] rd1_b, rd2_b, a0_b;
    logic        busy_b, done_b;
    logic [31:0] rd1_n, rd2_n, a0_n;
    logic        busy_n, done_n;

    regfile_param #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .A0_INDEX(10), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ren1(ren1), .ren2(ren2),
        .rd(rd), .WE3(WE3), .WD3(WD3), .clr(clr),
        .RD1(rd1_b), .RD2(rd2_b), .a0(a0_b), .busy(busy_b), .clr_done(done_b)
    );

    regfile_param #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .A0_INDEX(10), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ren1(ren1), .ren2(ren2),
        .rd(rd), .WE3(WE3), .WD3(WD3), .clr(clr),
        .RD1(rd1_n), .RD2(rd2_n), .a0(a0_n), .busy(busy_n), .clr_done(done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1_b, rd2_b, a0_b;
        logic [31:0] rd1_n, rd2_n, a0_n;
        logic        busy, done;
    } exp_t;

    typedef struct {
        logic [4:0]  r1, r2;
        logic        e1, e2;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp_rd1, exp_rd2;
    } vec_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;
    int stepno   = 0;
    int bcount   = 0;
    int dcount   = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_rd1b, m_rd2b, m_a0b, m_rd1n, m_rd2n, m_a0n;
    logic        m_busy, m_done, m_clear;
    logic [4:0]  m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, stepno, act, req);
        end
    endtask

    function automatic logic [31:0] mval(input logic [4:0] i, input logic byp, input logic wen,
                                         input logic [4:0] wa, input logic [31:0] wd);
        if (i == 5'd0) return 32'h0;
        if (byp && wen && (wa == i)) return wd;
        return m_regs[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_rd1b = 0; m_rd2b = 0; m_a0b = 0;
        m_rd1n = 0; m_rd2n = 0; m_a0n = 0;
        m_busy = 0; m_done = 0; m_clear = 0; m_cnt = 0;
        sb_q.delete();
    endtask

    // Drive one cycle, predict, wait for the edge, compare.
    task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic en1, input logic en2,
                        input logic [4:0] wa, input logic we, input logic [31:0] wd, input logic c);
        exp_t e;
        logic idle, wen;
        rs1 = r1; rs2 = r2; ren1 = en1; ren2 = en2;
        rd = wa; WE3 = we; WD3 = wd; clr = c;

        idle = !m_clear;
        wen  = we && (wa != 5'd0) && idle;
        if (idle && en1) begin
            m_rd1b = mval(r1, 1'b1, wen, wa, wd);
            m_rd1n = mval(r1, 1'b0, wen, wa, wd);
        end
        if (idle && en2) begin
            m_rd2b = mval(r2, 1'b1, wen, wa, wd);
            m_rd2n = mval(r2, 1'b0, wen, wa, wd);
        end
        m_a0b  = mval(5'd10, 1'b1, wen, wa, wd);
        m_a0n  = mval(5'd10, 1'b0, wen, wa, wd);
        m_done = 1'b0;
        if (idle) begin
            if (wen) m_regs[wa] = wd;
            if (c) begin
                m_clear = 1'b1; m_cnt = 5'd1; m_busy = 1'b1;
            end
        end else begin
            m_regs[m_cnt] = 32'h0;
            if (m_cnt == 5'd31) begin
                m_clear = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end
            m_cnt = m_cnt + 5'd1;
        end
        e = '{m_rd1b, m_rd2b, m_a0b, m_rd1n, m_rd2n, m_a0n, m_busy, m_done};
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        stepno++;
        e = sb_q.pop_front();
        chk("rd1_byp",   rd1_b,  e.rd1_b);
        chk("rd2_byp",   rd2_b,  e.rd2_b);
        chk("a0_byp",    a0_b,   e.a0_b);
        chk("rd1_nobyp", rd1_n,  e.rd1_n);
        chk("rd2_nobyp", rd2_n,  e.rd2_n);
        chk("a0_nobyp",  a0_n,   e.a0_n);
        chk("busy",      32'(busy_b), 32'(e.busy));
        chk("clr_done",  32'(done_b), 32'(e.done));
        chk("busy_n",    32'(busy_n), 32'(e.busy));
        chk("clr_done_n",32'(done_n), 32'(e.done));
        bcount += int'(busy_b);
        dcount += int'(done_b);
    endtask

    task automatic idle_step(input logic [4:0] r1, input logic [4:0] r2);
        step(r1, r2, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    // Assert reset between edges and check it acts without a clock edge.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rd1_b", rd1_b, 32'h0);
        chk("rst_rd2_b", rd2_b, 32'h0);
        chk("rst_a0_b",  a0_b,  32'h0);
        chk("rst_busy",  32'(busy_b), 32'h0);
        chk("rst_done",  32'(done_b), 32'h0);
        chk("rst_rd1_n", rd1_n, 32'h0);
        chk("rst_a0_n",  a0_n,  32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl [9];

    initial begin
        tbl[0] = '{5'd5,  5'd0,  1'b1, 1'b1, 5'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{5'd0,  5'd5,  1'b1, 1'b1, 5'd0,  1'b1, 32'h00001234, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{5'd5,  5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        tbl[3] = '{5'd10, 5'd7,  1'b1, 1'b0, 5'd10, 1'b1, 32'h00000042, 32'h00000042, 32'hA5A5A5A5};
        tbl[4] = '{5'd3,  5'd10, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,        32'h00000042, 32'h00000042};
        tbl[5] = '{5'd9,  5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 32'h0,        32'h00000042, 32'h0};
        tbl[6] = '{5'd1,  5'd31, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,        32'h00000042, 32'h0};
        tbl[7] = '{5'd31, 5'd31, 1'b1, 1'b0, 5'd31, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        tbl[8] = '{5'd0,  5'd31, 1'b1, 1'b1, 5'd0,  1'b0, 32'h0,        32'h0,        32'hFFFFFFFF};

        rst = 1'b1; rs1 = 0; rs2 = 0; ren1 = 0; ren2 = 0; rd = 0; WE3 = 0; WD3 = 0; clr = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("init_rd1", rd1_b, 32'h0);
        chk("init_a0",  a0_b,  32'h0);
        chk("init_busy", 32'(busy_b), 32'h0);
        rst = 1'b0;

        // Reset clears the array and outputs immediately
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 32'hDEADBEEF, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 32'h00000077, 1'b0);
        idle_step(5'd5, 5'd10);
        chk("pre_rst_rd1", rd1_b, 32'hDEADBEEF);
        chk("pre_rst_a0",  a0_b,  32'h00000077);
        mid_reset();
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        chk("post_rst_x5", rd1_b, 32'h0);

        // Vector table from a clean state
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r1, tbl[i].r2, tbl[i].e1, tbl[i].e2, tbl[i].wa, tbl[i].we, tbl[i].wd, 1'b0);
            chk("tbl_rd1", rd1_b, tbl[i].exp_rd1);
            chk("tbl_rd2", rd2_b, tbl[i].exp_rd2);
        end

        // Bypass versus no bypass on a same-cycle read of the written index
        mid_reset();
        step(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 32'hA5A5A5A5, 1'b0);
        chk("byp_same_cycle",   rd2_b, 32'hA5A5A5A5);
        chk("nobyp_same_cycle", rd2_n, 32'h0);
        idle_step(5'd0, 5'd7);
        chk("nobyp_next_read",  rd2_n, 32'hA5A5A5A5);

        // Soft clear: fill, sweep with writes attempted, verify all zero
        for (int i = 1; i < 32; i++)
            step(5'(i), 5'd0, 1'b1, 1'b0, 5'(i), 1'b1, 32'(i), 1'b0);
        bcount = 0; dcount = 0;
        step(5'd2, 5'd10, 1'b1, 1'b1, 5'd2, 1'b1, 32'h00000099, 1'b1);
        chk("clr_cycle_write_byp", rd1_b, 32'h00000099);
        chk("clr_cycle_a0",        a0_b,  32'd10);
        for (int i = 0; i < 31; i++)
            step(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 32'h00000BAD, 1'b0);
        chk("sweep_rd1_held", rd1_b, 32'h00000099);
        idle_step(5'd0, 5'd0);
        idle_step(5'd0, 5'd0);
        chk("sweep_busy_cycles", 32'(bcount), 32'd31);
        chk("sweep_done_pulses", 32'(dcount), 32'd1);
        for (int i = 0; i < 32; i++) begin
            idle_step(5'(i), 5'(31 - i));
            chk("after_sweep_rd1", rd1_b, 32'h0);
        end
        chk("after_sweep_a0", a0_b, 32'h0);

        // Reset during a sweep, then a complete sweep
        for (int i = 1; i < 32; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'(i), 1'b1, 32'(i + 100), 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 11; i++)
            idle_step(5'd0, 5'd0);
        chk("mid_sweep_busy", 32'(busy_b), 32'h1);
        mid_reset();
        idle_step(5'd20, 5'd31);
        chk("rst_sweep_x20", rd1_b, 32'h0);
        chk("rst_sweep_x31", rd2_b, 32'h0);
        idle_step(5'd29, 5'd30);
        chk("rst_sweep_x29", rd1_b, 32'h0);
        bcount = 0; dcount = 0;
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 33; i++)
            idle_step(5'd0, 5'd0);
        chk("resweep_busy_cycles", 32'(bcount), 32'd31);
        chk("resweep_done_pulses", 32'(dcount), 32'd1);

        // clr held high re-triggers a sweep on the first idle edge
        bcount = 0; dcount = 0;
        for (int i = 0; i < 70; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 40; i++)
            idle_step(5'd0, 5'd0);
        chk("held_clr_busy_cycles", 32'(bcount), 32'd93);
        chk("held_clr_done_pulses", 32'(dcount), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the CPU's 3-port integer register file: two synchronous read ports, one write port, and an observation output for register a0.
- Adds the following:
  - Hardwired-zero x0.
  - Optional write-to-read bypass.
  - Per-port read hold.
  - Asynchronous active-high reset clearing all state.
  - Soft-clear sequencer that sweeps every register to zero, one per cycle.
- Sits in the decode stage between the instruction decoder and the ALU; feeds RD1/RD2 to ALU operand muxes and a0 to the top-level output.

Parameters:
- ADDRESS_WIDTH, 5, register index width; NUM_REGS = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- A0_INDEX, 10, register mirrored on a0 (must be < NUM_REGS).
- BYPASS, 1, 1 = same-cycle write forwarded to reads/a0; 0 = reads return old array contents.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- rs1  in  ADDRESS_WIDTH  read port 1 index
- rs2  in  ADDRESS_WIDTH  read port 2 index
- ren1  in  1  read enable port 1 (0 = RD1 holds)
- ren2  in  1  read enable port 2 (0 = RD2 holds)
- rd  in  ADDRESS_WIDTH  write index
- WE3  in  1  write enable
- WD3  in  DATA_WIDTH  write data
- clr  in  1  soft-clear request, sampled only in IDLE
- RD1  out  DATA_WIDTH  registered read data port 1
- RD2  out  DATA_WIDTH  registered read data port 2
- a0  out  DATA_WIDTH  registered copy of reg[A0_INDEX]
- busy  out  1  high while clear sweep in progress
- clr_done  out  1  one-cycle pulse on final sweep write

Behaviour:
- Reset (rst=1, asynchronous, any time incl. mid-sweep):
  - all NUM_REGS entries = 0
  - RD1 = RD2 = a0 = 0
  - busy = 0, clr_done = 0
  - FSM = IDLE, sweep counter = 0
  - Takes effect without a clock edge.
- x0:
  - reads of index 0 always return 0
  - writes to rd=0 are discarded
  - bypass never forwards to index 0
- Write: at rising edge, if WE3=1, rd!=0 and FSM=IDLE, then reg[rd] <= WD3.
- Read, 1-cycle latency:
  - at rising edge, if renN=1 and FSM=IDLE, RDN <= val(rsN)
  - otherwise RDN holds its value (also held for the whole sweep)
- val(i):
  - 0 if i=0
  - else WD3 if BYPASS=1, WE3=1, rd=i and FSM=IDLE
  - else reg[i]
- a0: updated every edge (no enable) with val(A0_INDEX); during sweep it reflects array contents, reaching 0 once A0_INDEX is cleared.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clr=1 at edge k; counter <= 1; busy=1 from edge k. A WE3 in that same cycle is still performed, and reads complete normally (clr wins only for subsequent cycles).
  - CLEAR, each edge: reg[counter] <= 0; counter <= counter+1; WE3, ren1, ren2 and clr are ignored.
  - CLEAR -> IDLE: at the edge writing index NUM_REGS-1 (edge k+NUM_REGS-1); clr_done=1 for exactly the cycle following that edge; busy=0 after that edge.
  - Sweep length: busy is high for NUM_REGS-1 cycles (31 with defaults).
  - A clr held high continuously re-triggers a new sweep on the first IDLE edge.
- Counter width ADDRESS_WIDTH; no wrap beyond NUM_REGS-1; counter unused in IDLE.
- Simultaneous read and write to the same index:
  - BYPASS=1 -> new data
  - BYPASS=0 -> old data; the new value is visible one cycle later.

Test Plan:
- Reset: write 0xDEADBEEF to x5, assert rst mid-cycle -> RD1/RD2/a0 = 0 immediately; after release, reading rs1=5 gives RD1 = 0.
- x0: WE3=1, rd=0, WD3=0x1234; next cycle rs1=0 -> RD1 = 0; repeat with BYPASS=1 -> still 0.
- Bypass: WE3=1, rd=7, WD3=0xA5A5A5A5, rs2=7 in the same cycle -> RD2 = 0xA5A5A5A5 after that edge (BYPASS=1); with BYPASS=0, RD2 = prior value (0), then 0xA5A5A5A5 on the next read.
- a0/hold: write 0x00000042 to x10 -> a0 = 0x42 one edge later; ren1=0 with rs1 changing -> RD1 unchanged for 3 cycles.
- Soft clear: fill x1..x31 with index value, pulse clr -> busy high 31 cycles, clr_done single pulse; WE3 to x3 during the sweep is ignored; afterwards every register reads 0 and a0 = 0.
- Reset mid-sweep: assert rst at sweep cycle 12 -> busy = 0 immediately, FSM IDLE, all registers 0; a new clr afterwards completes normally in 31 cycles.
